// File: rtl/sd_card_dat_pkg.sv
// Shared constants, state encoding and default widths for the card-side DAT line engine.
package sd_card_dat_pkg;

  localparam int unsigned DefFifoWidth     = 32;
  localparam int unsigned DefBlockSzWidth  = 12;
  localparam int unsigned DefBlockCntWidth = 16;
  localparam int unsigned DefCrcNib        = 2;
  localparam int unsigned DefBusyCyc       = 4;
  localparam int unsigned DefNac           = 2;

  // Width of the shared gap/CRC/busy down-counter.
  localparam int unsigned CtrW = 8;

  localparam logic [3:0] DAT_START = 4'h0;
  localparam logic [3:0] DAT_END   = 4'hF;
  localparam logic [3:0] DAT_IDLE  = 4'hF;
  localparam logic [3:0] DAT_BUSY  = 4'hE;
  localparam logic [3:0] DAT_CRC   = 4'h0;

  typedef enum logic [10:0] {
    StIdle    = 11'h001,
    StRxWait  = 11'h002,
    StRxData  = 11'h004,
    StRxCrc   = 11'h008,
    StRxEnd   = 11'h010,
    StRxBusy  = 11'h020,
    StTxGap   = 11'h040,
    StTxStart = 11'h080,
    StTxData  = 11'h100,
    StTxCrc   = 11'h200,
    StTxEnd   = 11'h400
  } dat_state_e;

endpackage

// File: rtl/sd_card_dat_if.sv
// DAT bus, command and storage-port signals between the host side and the card engine.
interface sd_card_dat_if
  import sd_card_dat_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH      = DefFifoWidth,
  parameter int unsigned BLOCK_SZ_WIDTH  = DefBlockSzWidth,
  parameter int unsigned BLOCK_CNT_WIDTH = DefBlockCntWidth
) ();

  logic [3:0]                 DAT_din;
  logic [3:0]                 DAT_dout;
  logic                       DAT_dout_oe;
  logic                       write_cmd;
  logic                       read_cmd;
  logic                       multiple;
  logic [BLOCK_SZ_WIDTH-1:0]  block_sz;
  logic [BLOCK_CNT_WIDTH-1:0] block_cnt;
  logic [FIFO_WIDTH-1:0]      mem_rd_data;
  logic                       mem_rd_enb;
  logic [FIFO_WIDTH-1:0]      mem_wr_data;
  logic                       mem_wr_enb;
  logic                       card_busy;
  logic                       done;
  logic                       err;

  modport master (
    output DAT_din, write_cmd, read_cmd, multiple, block_sz, block_cnt, mem_rd_data,
    input  DAT_dout, DAT_dout_oe, mem_rd_enb, mem_wr_data, mem_wr_enb, card_busy, done, err
  );

  modport slave (
    input  DAT_din, write_cmd, read_cmd, multiple, block_sz, block_cnt, mem_rd_data,
    output DAT_dout, DAT_dout_oe, mem_rd_enb, mem_wr_data, mem_wr_enb, card_busy, done, err
  );

endinterface

// File: rtl/sd_card_dat_nibble_shreg.sv
// Word-wide load/shift register with nibble in/out paths and a word-complete flag.
module dat_nibble_shreg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] load_data_i,
  input  logic [3:0]       nib_i,
  output logic [Width-1:0] shifted_o,
  output logic [3:0]       nib_o,
  output logic             last_o
);

  localparam int unsigned NibPerWord = Width / 4;
  localparam int unsigned CntW       = (NibPerWord > 1) ? $clog2(NibPerWord) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NibPerWord - 1);

  logic [Width-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // shifted_o is the word as it stands once nib_i has been shifted in.
  assign shifted_o = {data_q[Width-5:0], nib_i};
  assign nib_o     = data_q[Width-1 -: 4];
  assign last_o    = (cnt_q == LastCnt);

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = shifted_o;
      cnt_d  = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_card_dat.sv
// Card-side DAT engine: receives framed write blocks with busy reply, transmits framed read
// blocks from a first-word-fall-through storage port.
module sd_card_dat
  import sd_card_dat_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH      = DefFifoWidth,
  parameter int unsigned BLOCK_SZ_WIDTH  = DefBlockSzWidth,
  parameter int unsigned BLOCK_CNT_WIDTH = DefBlockCntWidth,
  parameter int unsigned CRC_NIB         = DefCrcNib,
  parameter int unsigned BUSY_CYC        = DefBusyCyc,
  parameter int unsigned NAC             = DefNac
) (
  input logic          sd_clk,
  input logic          rst,
  sd_card_dat_if.slave bus
);

  localparam int unsigned NibW = BLOCK_SZ_WIDTH + 1;
  localparam logic [NibW-1:0]            NibOne = NibW'(1);
  localparam logic [BLOCK_CNT_WIDTH-1:0] BlkOne = BLOCK_CNT_WIDTH'(1);
  localparam logic [CtrW-1:0]            CtrOne = CtrW'(1);
  localparam logic [CtrW-1:0]            NacLd  = CtrW'(NAC);
  localparam logic [CtrW-1:0]            CrcLd  = CtrW'(CRC_NIB);
  localparam logic [CtrW-1:0]            BusyLd = CtrW'(BUSY_CYC);

  dat_state_e                 state_q, state_d;
  logic [BLOCK_SZ_WIDTH-1:0]  blk_sz_q, blk_sz_d;
  logic [BLOCK_CNT_WIDTH-1:0] blk_q, blk_d, blk_dec, blk_cmd;
  logic [NibW-1:0]            nib_q, nib_d, nib_dec, nib_full;
  logic [CtrW-1:0]            cnt_q, cnt_d, cnt_dec;
  logic [3:0]                 dout_q, dout_d;
  logic                       oe_q, oe_d;
  logic                       rd_enb_q, rd_enb_d;
  logic [FIFO_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                       wr_enb_q, wr_enb_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                  sh_clr, sh_load, sh_shift, sh_last;
  logic [FIFO_WIDTH-1:0] sh_shifted;
  logic [3:0]            sh_nib;

  dat_nibble_shreg #(
    .Width (FIFO_WIDTH)
  ) u_shreg (
    .clk_i       (sd_clk),
    .rst_i       (rst),
    .clr_i       (sh_clr),
    .load_i      (sh_load),
    .shift_i     (sh_shift),
    .load_data_i (bus.mem_rd_data),
    .nib_i       (bus.DAT_din),
    .shifted_o   (sh_shifted),
    .nib_o       (sh_nib),
    .last_o      (sh_last)
  );

  // Counters saturate at zero rather than wrapping.
  assign blk_dec  = (blk_q != '0) ? blk_q - BlkOne : '0;
  assign nib_dec  = (nib_q != '0) ? nib_q - NibOne : '0;
  assign cnt_dec  = (cnt_q != '0) ? cnt_q - CtrOne : '0;
  assign nib_full = {blk_sz_q, 1'b0};
  assign blk_cmd  = bus.multiple ? bus.block_cnt : BlkOne;

  always_comb begin
    state_d   = state_q;
    blk_sz_d  = blk_sz_q;
    blk_d     = blk_q;
    nib_d     = nib_q;
    cnt_d     = cnt_q;
    dout_d    = DAT_IDLE;
    oe_d      = 1'b0;
    rd_enb_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_enb_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.write_cmd && bus.read_cmd) begin
          err_d = 1'b1;
        end else if (bus.write_cmd || bus.read_cmd) begin
          blk_sz_d = bus.block_sz;
          blk_d    = blk_cmd;
          if (bus.block_sz == '0 || blk_cmd == '0) begin
            err_d = 1'b1;
          end else if (bus.write_cmd) begin
            state_d = StRxWait;
          end else begin
            state_d = StTxGap;
            cnt_d   = NacLd;
          end
        end
      end

      StRxWait: begin
        if (bus.DAT_din == DAT_START) begin
          state_d = StRxData;
          nib_d   = nib_full;
          sh_clr  = 1'b1;
        end
      end

      StRxData: begin
        sh_shift = 1'b1;
        nib_d    = nib_dec;
        if (sh_last) begin
          wr_enb_d  = 1'b1;
          wr_data_d = sh_shifted;
        end
        if (nib_q <= NibOne) begin
          state_d = (CRC_NIB == 0) ? StRxEnd : StRxCrc;
          cnt_d   = CrcLd;
        end
      end

      StRxCrc: begin
        cnt_d = cnt_dec;
        if (cnt_q <= CtrOne) state_d = StRxEnd;
      end

      StRxEnd: begin
        if (bus.DAT_din == DAT_END) begin
          state_d = StRxBusy;
          blk_d   = blk_dec;
          cnt_d   = BusyLd;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end

      // Busy for BUSY_CYC cycles, then one more cycle to release with done.
      StRxBusy: begin
        if (cnt_q != '0) begin
          oe_d   = 1'b1;
          dout_d = DAT_BUSY;
          cnt_d  = cnt_dec;
        end else if (blk_q != '0) begin
          state_d = StRxWait;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      StTxGap: begin
        cnt_d = cnt_dec;
        if (cnt_q <= CtrOne) state_d = StTxStart;
      end

      StTxStart: begin
        oe_d     = 1'b1;
        dout_d   = DAT_START;
        sh_load  = 1'b1;
        rd_enb_d = 1'b1;
        nib_d    = nib_full;
        state_d  = StTxData;
      end

      StTxData: begin
        oe_d   = 1'b1;
        dout_d = sh_nib;
        nib_d  = nib_dec;
        if (nib_q <= NibOne) begin
          state_d = (CRC_NIB == 0) ? StTxEnd : StTxCrc;
          cnt_d   = CrcLd;
        end else if (sh_last) begin
          sh_load  = 1'b1;
          rd_enb_d = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end

      StTxCrc: begin
        oe_d   = 1'b1;
        dout_d = DAT_CRC;
        cnt_d  = cnt_dec;
        if (cnt_q <= CtrOne) state_d = StTxEnd;
      end

      StTxEnd: begin
        oe_d   = 1'b1;
        dout_d = DAT_END;
        blk_d  = blk_dec;
        if (blk_q > BlkOne) begin
          state_d = StTxGap;
          cnt_d   = NacLd;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      blk_sz_q  <= '0;
      blk_q     <= '0;
      nib_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= DAT_IDLE;
      oe_q      <= 1'b0;
      rd_enb_q  <= 1'b0;
      wr_data_q <= '0;
      wr_enb_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_sz_q  <= blk_sz_d;
      blk_q     <= blk_d;
      nib_q     <= nib_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rd_enb_q  <= rd_enb_d;
      wr_data_q <= wr_data_d;
      wr_enb_q  <= wr_enb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.DAT_dout    = dout_q;
  assign bus.DAT_dout_oe = oe_q;
  assign bus.mem_rd_enb  = rd_enb_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.mem_wr_enb  = wr_enb_q;
  assign bus.card_busy   = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sd_card_dat.sv
// Directed bench for sd_card_dat: write, multi-block read, framing and command errors, reset.
module tb_sd_card_dat;

  logic sd_clk = 1'b0;
  logic rst;
  always #5 sd_clk = ~sd_clk;

  sd_card_dat_if bus ();

  sd_card_dat dut (
    .sd_clk (sd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Storage model: FWFT read array and a log of written words.
  logic [31:0] mem [16];
  logic [3:0]  rd_ptr = 4'd0;
  logic [31:0] wr_log [16];
  int          wr_cnt = 0;

  assign bus.mem_rd_data = mem[rd_ptr];

  always @(posedge sd_clk) begin
    if (bus.mem_rd_enb) rd_ptr <= rd_ptr + 4'd1;
    if (bus.mem_wr_enb) begin
      wr_log[wr_cnt % 16] <= bus.mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.DAT_dout_oe, bus.DAT_dout} !== 5'h0F) begin
      n_fail++;
      $display("FAIL reset_bus: got %h expected %h", {bus.DAT_dout_oe, bus.DAT_dout}, 5'h0F);
    end
    n_tests++;
    if ({bus.card_busy, bus.done, bus.err, bus.mem_rd_enb, bus.mem_wr_enb} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.card_busy, bus.done, bus.err, bus.mem_rd_enb, bus.mem_wr_enb});
    end
    n_tests++;
    if (bus.mem_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wr_data: got %h expected 0", bus.mem_wr_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_single();
    logic [31:0] w [2];
    int base;
    w[0] = 32'h12345678;
    w[1] = 32'h9ABCDEF0;
    base = wr_cnt;
    bus.block_sz  = 12'd8;
    bus.multiple  = 1'b0;
    bus.write_cmd = 1'b1;
    tick();
    bus.write_cmd = 1'b0;
    n_tests++;
    if (bus.card_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy_flag: got %b expected 1", bus.card_busy);
    end
    bus.DAT_din = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_tests++;
      if (bus.mem_wr_enb !== (i == 8)) begin
        n_fail++;
        $display("FAIL wr_enb_%0d: got %b expected %b", i, bus.mem_wr_enb, (i == 8));
      end
      bus.DAT_din = w[i / 8][31 - 4 * (i % 8) -: 4];
    end
    tick();
    n_tests++;
    if (bus.mem_wr_enb !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_enb_last: got %b expected 1", bus.mem_wr_enb);
    end
    bus.DAT_din = 4'h0;
    tick();
    bus.DAT_din = 4'h0;
    tick();
    bus.DAT_din = 4'hF;
    tick();
    n_tests++;
    if ({bus.DAT_dout_oe, bus.DAT_dout} !== 5'h0F) begin
      n_fail++;
      $display("FAIL wr_end_edge: got %h expected %h", {bus.DAT_dout_oe, bus.DAT_dout}, 5'h0F);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_tests++;
      if ({bus.done, bus.DAT_dout_oe, bus.DAT_dout} !== 6'h1E) begin
        n_fail++;
        $display("FAIL wr_busy_%0d: got %h expected %h", j,
                 {bus.done, bus.DAT_dout_oe, bus.DAT_dout}, 6'h1E);
      end
    end
    tick();
    n_tests++;
    if ({bus.done, bus.DAT_dout_oe, bus.DAT_dout} !== 6'h2F) begin
      n_fail++;
      $display("FAIL wr_release: got %h expected %h",
               {bus.done, bus.DAT_dout_oe, bus.DAT_dout}, 6'h2F);
    end
    tick();
    n_tests++;
    if ({bus.done, bus.card_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_idle: got %b expected 00", {bus.done, bus.card_busy});
    end
    n_tests++;
    if (wr_cnt !== base + 2) begin
      n_fail++;
      $display("FAIL wr_count: got %0d expected %0d", wr_cnt, base + 2);
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (wr_log[(base + k) % 16] !== w[k]) begin
        n_fail++;
        $display("FAIL wr_word_%0d: got %h expected %h", k, wr_log[(base + k) % 16], w[k]);
      end
    end
  endtask

  task automatic test_read_multi();
    logic [31:0] w [2];
    logic [4:0]  exp [$];
    logic [3:0]  p0;
    w[0] = 32'hDEADBEEF;
    w[1] = 32'hCAFEF00D;
    p0 = rd_ptr;
    mem[p0]        = w[0];
    mem[p0 + 4'd1] = w[1];
    for (int b = 0; b < 2; b++) begin
      exp.push_back(5'h0F);
      exp.push_back(5'h0F);
      exp.push_back(5'h10);
      for (int n = 0; n < 8; n++) exp.push_back({1'b1, w[b][31 - 4 * n -: 4]});
      exp.push_back(5'h10);
      exp.push_back(5'h10);
      exp.push_back(5'h1F);
    end
    exp.push_back(5'h0F);
    bus.block_sz  = 12'd4;
    bus.block_cnt = 16'd2;
    bus.multiple  = 1'b1;
    bus.read_cmd  = 1'b1;
    tick();
    bus.read_cmd = 1'b0;
    n_tests++;
    if (bus.card_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_busy_flag: got %b expected 1", bus.card_busy);
    end
    for (int j = 0; j < exp.size(); j++) begin
      tick();
      n_tests++;
      if ({bus.DAT_dout_oe, bus.DAT_dout} !== exp[j]) begin
        n_fail++;
        $display("FAIL rd_bus_%0d: got %h expected %h", j, {bus.DAT_dout_oe, bus.DAT_dout}, exp[j]);
      end
      n_tests++;
      if (bus.done !== (j == 27)) begin
        n_fail++;
        $display("FAIL rd_done_%0d: got %b expected %b", j, bus.done, (j == 27));
      end
    end
    n_tests++;
    if (rd_ptr !== p0 + 4'd2) begin
      n_fail++;
      $display("FAIL rd_pops: got %0d expected %0d", rd_ptr, p0 + 4'd2);
    end
    n_tests++;
    if (bus.card_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_idle: got %b expected 0", bus.card_busy);
    end
  endtask

  task automatic test_end_err();
    logic [31:0] w;
    w = 32'hA5C3E1F7;
    bus.block_sz  = 12'd4;
    bus.multiple  = 1'b0;
    bus.write_cmd = 1'b1;
    tick();
    bus.write_cmd = 1'b0;
    bus.DAT_din = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.DAT_din = w[31 - 4 * i -: 4];
    end
    tick();
    bus.DAT_din = 4'h0;
    tick();
    bus.DAT_din = 4'h0;
    tick();
    bus.DAT_din = 4'h7;
    tick();
    bus.DAT_din = 4'hF;
    n_tests++;
    if ({bus.err, bus.card_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL end_err_flag: got %b expected 10", {bus.err, bus.card_busy});
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      n_tests++;
      if ({bus.err, bus.done, bus.DAT_dout_oe, bus.DAT_dout} !== 7'h0F) begin
        n_fail++;
        $display("FAIL end_err_nobusy_%0d: got %h expected %h", j,
                 {bus.err, bus.done, bus.DAT_dout_oe, bus.DAT_dout}, 7'h0F);
      end
    end
  endtask

  task automatic test_both_cmds();
    bus.block_sz  = 12'd4;
    bus.multiple  = 1'b0;
    bus.write_cmd = 1'b1;
    bus.read_cmd  = 1'b1;
    tick();
    bus.write_cmd = 1'b0;
    bus.read_cmd  = 1'b0;
    n_tests++;
    if ({bus.err, bus.card_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_err: got %b expected 10", {bus.err, bus.card_busy});
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_tests++;
      if ({bus.err, bus.card_busy, bus.DAT_dout_oe} !== 3'b000) begin
        n_fail++;
        $display("FAIL both_idle_%0d: got %b expected 000", j,
                 {bus.err, bus.card_busy, bus.DAT_dout_oe});
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] w;
    logic [4:0]  exp [$];
    mem[rd_ptr]  = 32'h11223344;
    bus.block_sz = 12'd4;
    bus.multiple = 1'b0;
    bus.read_cmd = 1'b1;
    tick();
    bus.read_cmd = 1'b0;
    repeat (5) tick();
    n_tests++;
    if ({bus.DAT_dout_oe, bus.DAT_dout} !== 5'h11) begin
      n_fail++;
      $display("FAIL rst_tx_pre: got %h expected %h", {bus.DAT_dout_oe, bus.DAT_dout}, 5'h11);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.card_busy, bus.DAT_dout_oe, bus.DAT_dout} !== 6'h0F) begin
      n_fail++;
      $display("FAIL rst_tx_release: got %h expected %h",
               {bus.card_busy, bus.DAT_dout_oe, bus.DAT_dout}, 6'h0F);
    end
    tick();
    w = 32'h0F1E2D3C;
    mem[rd_ptr] = w;
    exp.push_back(5'h0F);
    exp.push_back(5'h0F);
    exp.push_back(5'h10);
    for (int n = 0; n < 8; n++) exp.push_back({1'b1, w[31 - 4 * n -: 4]});
    exp.push_back(5'h10);
    exp.push_back(5'h10);
    exp.push_back(5'h1F);
    exp.push_back(5'h0F);
    bus.read_cmd = 1'b1;
    tick();
    bus.read_cmd = 1'b0;
    for (int j = 0; j < exp.size(); j++) begin
      tick();
      n_tests++;
      if ({bus.done, bus.DAT_dout_oe, bus.DAT_dout} !== {(j == 13), exp[j]}) begin
        n_fail++;
        $display("FAIL rst_reread_%0d: got %h expected %h", j,
                 {bus.done, bus.DAT_dout_oe, bus.DAT_dout}, {(j == 13), exp[j]});
      end
    end
  endtask

  task automatic test_zero_size();
    bus.block_sz  = 12'd0;
    bus.multiple  = 1'b0;
    bus.write_cmd = 1'b1;
    tick();
    bus.write_cmd = 1'b0;
    n_tests++;
    if ({bus.err, bus.card_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_sz_err: got %b expected 10", {bus.err, bus.card_busy});
    end
    bus.DAT_din = 4'h0;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_tests++;
      if ({bus.card_busy, bus.DAT_dout_oe, bus.mem_wr_enb} !== 3'b000) begin
        n_fail++;
        $display("FAIL zero_sz_quiet_%0d: got %b expected 000", j,
                 {bus.card_busy, bus.DAT_dout_oe, bus.mem_wr_enb});
      end
    end
    bus.DAT_din   = 4'hF;
    bus.block_sz  = 12'd4;
    bus.multiple  = 1'b1;
    bus.block_cnt = 16'd0;
    bus.read_cmd  = 1'b1;
    tick();
    bus.read_cmd = 1'b0;
    n_tests++;
    if ({bus.err, bus.card_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_cnt_err: got %b expected 10", {bus.err, bus.card_busy});
    end
    tick();
    n_tests++;
    if ({bus.err, bus.card_busy, bus.DAT_dout_oe, bus.mem_rd_enb} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_cnt_quiet: got %b expected 0000",
               {bus.err, bus.card_busy, bus.DAT_dout_oe, bus.mem_rd_enb});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst           = 1'b1;
    bus.DAT_din   = 4'hF;
    bus.write_cmd = 1'b0;
    bus.read_cmd  = 1'b0;
    bus.multiple  = 1'b0;
    bus.block_sz  = 12'd0;
    bus.block_cnt = 16'd0;

    test_reset();
    test_write_single();
    test_read_multi();
    test_end_err();
    test_both_cmds();
    test_reset_mid_tx();
    test_zero_size();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
